// File: rtl/seq_factorial.sv
// Sequential factorial engine: one multiply per clock behind a start/done handshake.
// The result is truncated to W bits, and a sticky flag reports any product bits lost above W.
module seq_factorial #(
    parameter int N = 4,
    parameter int W = 10 * N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] number,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] factorial,
    output logic         overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [N-1:0] NUM_TWO = N'(2);
    localparam logic [N-1:0] NUM_ONE = N'(1);
    localparam logic [W-1:0] ACC_ONE = W'(1);

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   n_q, n_d;
    logic [N-1:0]   i_q, i_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   factorial_q, factorial_d;
    logic           overflow_q, overflow_d;
    logic [W+N-1:0] prod;

    // Full-width product so the bits above W can be folded into the sticky flag.
    assign prod = {{N{1'b0}}, acc_q} * {{W{1'b0}}, i_q};

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        factorial_d = factorial_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (number < NUM_TWO) begin
                        state_d     = S_DONE;
                        factorial_d = ACC_ONE;
                        overflow_d  = 1'b0;
                    end else begin
                        state_d = S_CALC;
                        n_d     = number;
                        acc_d   = ACC_ONE;
                        i_d     = NUM_TWO;
                        ovf_d   = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                acc_d = prod[W-1:0];
                ovf_d = ovf_q | (|prod[W+N-1:W]);
                // Equality exit means i never has to step past the largest operand.
                if (i_q == n_q) begin
                    state_d     = S_DONE;
                    factorial_d = acc_d;
                    overflow_d  = ovf_d;
                end else begin
                    i_d = i_q + NUM_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            i_q         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            factorial_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            i_q         <= i_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            factorial_q <= factorial_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign factorial = factorial_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_factorial.sv
// Directed bench for seq_factorial (N=4, W=40): latency, results, overflow, reset abort.
module tb_seq_factorial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  number;
    logic        busy;
    logic        done;
    logic [39:0] factorial;
    logic        overflow;

    int total;
    int bad;

    seq_factorial #(.N(4), .W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .number    (number),
        .busy      (busy),
        .done      (done),
        .factorial (factorial),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        chk("done_and_busy", {63'd0, done & busy}, 64'd0);
    endtask

    function automatic longint unsigned full_fact(input int n);
        longint unsigned r;
        r = 1;
        for (int k = 2; k <= n; k++) r = r * longint'(k);
        return r;
    endfunction

    // Issues start in the current cycle and waits for done; reports latency in cycles.
    task automatic do_calc(input int n, output int lat);
        number = 4'(n);
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        while (done !== 1'b1 && lat < 40) begin
            chk("busy_in_calc", {63'd0, busy}, 64'd1);
            step();
            lat++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic calc_and_check(input string tag, input int n);
        int lat;
        longint unsigned full;
        logic [63:0] mask;
        mask = 64'h0000_00FF_FFFF_FFFF;
        full = full_fact(n);
        do_calc(n, lat);
        chk({tag, "_latency"}, 64'(lat), (n < 2) ? 64'd1 : 64'(n));
        chk({tag, "_fact"}, {24'd0, factorial}, full & mask);
        chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, (full > mask)});
    endtask

    initial begin
        int lat;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        number = 4'd0;
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_fact", {24'd0, factorial}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        rst = 1'b0;
        step();

        // T1: trivial operands finish in one cycle
        do_calc(0, lat);
        chk("t1_n0_lat", 64'(lat), 64'd1);
        chk("t1_n0_fact", {24'd0, factorial}, 64'd1);
        chk("t1_n0_busy", {63'd0, busy}, 64'd0);
        step();
        chk("t1_done_pulse", {63'd0, done}, 64'd0);
        do_calc(1, lat);
        chk("t1_n1_lat", 64'(lat), 64'd1);
        chk("t1_n1_fact", {24'd0, factorial}, 64'd1);
        chk("t1_n1_ovf", {63'd0, overflow}, 64'd0);
        step();

        // T2: 4! with busy in cycles c+1..c+3
        do_calc(4, lat);
        chk("t2_lat", 64'(lat), 64'd4);
        chk("t2_fact", {24'd0, factorial}, 64'd24);
        chk("t2_ovf", {63'd0, overflow}, 64'd0);
        step();
        chk("t2_idle_done", {63'd0, done}, 64'd0);
        chk("t2_hold_fact", {24'd0, factorial}, 64'd24);

        // T3: largest value that fits, then the first one that overflows
        do_calc(14, lat);
        chk("t3_14_lat", 64'(lat), 64'd14);
        chk("t3_14_fact", {24'd0, factorial}, 64'd87178291200);
        chk("t3_14_ovf", {63'd0, overflow}, 64'd0);
        step();
        do_calc(15, lat);
        chk("t3_15_lat", 64'(lat), 64'd15);
        chk("t3_15_fact", {24'd0, factorial}, 64'd208162740224);
        chk("t3_15_ovf", {63'd0, overflow}, 64'd1);
        step();

        // T4: start during CALC is ignored; start in the done cycle is accepted
        number = 4'd5;
        start  = 1'b1;
        step();
        lat    = 1;
        number = 4'd3;
        step();
        lat    = 2;
        start  = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("t4_lat", 64'(lat), 64'd5);
        chk("t4_fact", {24'd0, factorial}, 64'd120);
        do_calc(3, lat);
        chk("t4_b2b_lat", 64'(lat), 64'd3);
        chk("t4_b2b_fact", {24'd0, factorial}, 64'd6);
        step();

        // T5: reset in the 4th CALC cycle abandons the calculation
        number = 4'd10;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        step();
        step();
        chk("t5_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_done", {63'd0, done}, 64'd0);
        chk("t5_fact", {24'd0, factorial}, 64'd0);
        chk("t5_ovf", {63'd0, overflow}, 64'd0);
        step();
        chk("t5_no_done", {63'd0, done}, 64'd0);
        do_calc(6, lat);
        chk("t5_6_lat", 64'(lat), 64'd6);
        chk("t5_6_fact", {24'd0, factorial}, 64'd720);
        step();

        // T6: random operands with random idle gaps, against the reference model
        for (int t = 0; t < 24; t++) begin
            int n;
            int gap;
            n   = int'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
            calc_and_check($sformatf("t6_%0d_n%0d", t, n), n);
        end
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
